// File: rtl/debouncing_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : debouncing_pkg
//  Description : Shared constants and helper function for the push-button
//                debouncer (default sample period, synchroniser depth and
//                the counter-width function).
//  Revision    : 1.0 - initial release
// ============================================================================
package debouncing_pkg;

    localparam int DEF_SAMPLE_PERIOD = 16;
    localparam int DEF_SYNC_STAGES   = 2;

    // Ceiling log2 of a period, never less than one bit so a counter exists.
    function automatic int cnt_width(input int period);
        int w;
        int v;
        w = 0;
        v = period - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : debounce_tick_gen
//  Description : Free-running wrap counter 0..SAMPLE_PERIOD-1; tick is high
//                for one clk when the count sits at its last value.
//  Revision    : 1.0 - initial release
// ============================================================================
module debounce_tick_gen
    import debouncing_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            c_CW   = cnt_width(SAMPLE_PERIOD);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(SAMPLE_PERIOD - 1);

    logic [c_CW-1:0] r_count;
    logic            w_last;

    assign w_last = (r_count == c_LAST);

    // Wrap counter: restarts from zero on reset release and after the last count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(1);
        end
    end

    assign tick = w_last;

endmodule
`default_nettype wire

// File: rtl/debouncing.sv
`default_nettype none
// ============================================================================
//  Module      : debouncing
//  Description : Push-button debouncer. The raw button is synchronised, then
//                sampled on a slow tick through two stages; dbsig follows the
//                stages when they agree and holds when they differ.
//                Optional build macro DEBOUNCE_LED_TOGGLE_EN turns LED into a
//                press-to-toggle register instead of a copy of dbsig.
//  Revision    : 1.0 - initial release
// ============================================================================
module debouncing
    import debouncing_pkg::*;
#(
    parameter int SAMPLE_PERIOD = DEF_SAMPLE_PERIOD,
    parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic LED,
    output logic dbsig,
    output logic button_out1,
    output logic button_out2
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_btn_s;
    logic                   w_tick;
    logic                   r_b1;
    logic                   r_b2;
    logic                   r_dbsig;

    // Metastability chain: btn enters at bit 0, the top bit is the safe copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn};
        end
    end

    assign w_btn_s = r_sync[SYNC_STAGES-1];

    debounce_tick_gen #(
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (w_tick)
    );

    // Two sample stages advance only on a tick and hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b1 <= 1'b0;
            r_b2 <= 1'b0;
        end else if (w_tick) begin
            r_b1 <= w_btn_s;
            r_b2 <= r_b1;
        end
    end

    // Hysteresis: follow the stages when they agree, otherwise keep the level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dbsig <= 1'b0;
        end else if (r_b1 && r_b2) begin
            r_dbsig <= 1'b1;
        end else if (!r_b1 && !r_b2) begin
            r_dbsig <= 1'b0;
        end
    end

    assign button_out1 = r_b1;
    assign button_out2 = r_b2;
    assign dbsig       = r_dbsig;

`ifdef DEBOUNCE_LED_TOGGLE_EN
    logic r_db_d;
    logic r_led;

    // Press-to-toggle: LED flips one clk after every debounced press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_db_d <= 1'b0;
            r_led  <= 1'b0;
        end else begin
            r_db_d <= r_dbsig;
            r_led  <= r_led ^ (r_dbsig & ~r_db_d);
        end
    end

    assign LED = r_led;
`else
    assign LED = r_dbsig;
`endif

endmodule
`default_nettype wire

// File: tb/tb_debouncing.sv
`default_nettype none
// ============================================================================
//  Module      : tb_debouncing
//  Description : Randomised, scoreboard-checked bench for the debouncer.
//                The reference model records btn per clock edge and derives
//                the sample stages from which ticks have elapsed.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_debouncing;

    localparam int P = 16;
    localparam int S = 2;

    logic clk;
    logic rst_n;
    logic btn;
    logic LED;
    logic dbsig;
    logic button_out1;
    logic button_out2;

    int tests;
    int fails;

    typedef struct packed {
        logic b1;
        logic b2;
        logic db;
        logic led;
    } exp_t;

    exp_t sb[$];
    logic hist[$];
    logic db_m;
    logic db_mm;
    logic led_m;
    int   db_rises;
    logic db_seen;

    debouncing #(
        .SAMPLE_PERIOD (P),
        .SYNC_STAGES   (S)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .LED         (LED),
        .dbsig       (dbsig),
        .button_out1 (button_out1),
        .button_out2 (button_out2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Value captured by sample tick j: btn as it stood S edges before that tick.
    function automatic logic sample_of(input int j);
        int idx;
        idx = j * P + P - 1 - S;
        if (idx < 0) return 1'b0;
        return hist[idx];
    endfunction

    // Sample stage contents after edge e (e = -1 means before any edge).
    task automatic stages_after(input int e, output logic s1, output logic s2);
        int m;
        m  = (e + 1) / P;
        s1 = (m >= 1) ? sample_of(m - 1) : 1'b0;
        s2 = (m >= 2) ? sample_of(m - 2) : 1'b0;
    endtask

    task automatic model_clear();
        hist.delete();
        db_m  = 1'b0;
        db_mm = 1'b0;
        led_m = 1'b0;
    endtask

    // Advance the model by one clock edge with btn = b and queue the expectation.
    task automatic model_edge(input logic b);
        int   k;
        logic p1, p2, c1, c2, db_n;
        exp_t e;
        hist.push_back(b);
        k = hist.size() - 1;
        stages_after(k - 1, p1, p2);
        if (p1 && p2)        db_n = 1'b1;
        else if (!p1 && !p2) db_n = 1'b0;
        else                 db_n = db_m;
`ifdef DEBOUNCE_LED_TOGGLE_EN
        led_m = led_m ^ (db_m & ~db_mm);
`endif
        db_mm = db_m;
        db_m  = db_n;
`ifndef DEBOUNCE_LED_TOGGLE_EN
        led_m = db_m;
`endif
        stages_after(k, c1, c2);
        e.b1  = c1;
        e.b2  = c2;
        e.db  = db_m;
        e.led = led_m;
        sb.push_back(e);
    endtask

    task automatic step(input logic b);
        @(negedge clk);
        rst_n = 1'b1;
        btn   = b;
        model_edge(b);
    endtask

    task automatic step_rst(input logic b);
        @(negedge clk);
        rst_n = 1'b0;
        btn   = b;
        model_clear();
        sb.push_back('0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Drive btn to val and count edges until dbsig follows; bounded.
    task automatic measure(input logic val, input string name);
        int n;
        step(val);
        n = 0;
        do begin
            step(val);
            n++;
        end while (dbsig !== val && n < 60);
        tests++;
        if (n < S + P + 1 || n > S + 2 * P + 1 || dbsig !== val) begin
            fails++;
            $display("FAIL %s latency: got %0d edges, required %0d..%0d", name, n,
                     S + P + 1, S + 2 * P + 1);
        end
    endtask

    // Monitor: compare every cycle's outputs against the oldest expectation.
    initial begin
        db_seen  = 1'b0;
        db_rises = 0;
        forever begin
            @(posedge clk);
            #1;
            if (dbsig === 1'b1 && db_seen === 1'b0) db_rises++;
            db_seen = dbsig;
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                tests++;
                if ({button_out1, button_out2, dbsig, LED} !== {e.b1, e.b2, e.db, e.led}) begin
                    fails++;
                    $display("FAIL cycle: got b1=%b b2=%b db=%b led=%b expected b1=%b b2=%b db=%b led=%b at %0t",
                             button_out1, button_out2, dbsig, LED, e.b1, e.b2, e.db, e.led, $time);
                end
            end
        end
    end

    initial begin
        int r0;
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        btn   = 1'b1;
        model_clear();

        // Reset held with btn high: everything stays cleared.
        repeat (10) step_rst(1'b1);
        check("reset_outputs", {button_out1, button_out2, dbsig, LED}, 4'b0000);

        // Release with btn still high, then idle low.
        repeat (20) step(1'b1);
        repeat (60) step(1'b0);

        // Clean press and hold, then release.
        measure(1'b1, "press");
        repeat (200) step(1'b1);
        check("press_held", dbsig, 1'b1);
        measure(1'b0, "release");
        repeat (40) step(1'b0);

        // Short glitches must never reach dbsig.
        r0 = db_rises;
        repeat (5) begin
            repeat (5)  step(1'b1);
            repeat (35) step(1'b0);
        end
        check("glitch_rises", db_rises - r0, 0);

        // Bounce then settle high: exactly one rising transition.
        r0 = db_rises;
        for (int i = 0; i < 10; i++) begin
            repeat (3) step(i[0] ? 1'b0 : 1'b1);
        end
        repeat (100) step(1'b1);
        check("bounce_rises", db_rises - r0, 1);
        check("bounce_level", dbsig, 1'b1);

        // Asynchronous reset pulse between edges while pressed.
        step(1'b1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", {button_out1, button_out2, dbsig, LED}, 4'b0000);
        #2 rst_n = 1'b1;
        void'(sb.pop_back());
        model_clear();
        model_edge(1'b1);
        begin
            int n;
            n = 0;
            while (dbsig !== 1'b1 && n < 60) begin
                step(1'b1);
                n++;
            end
            check("reassert_bound", (n <= S + 2 * P + 1) ? 1 : 0, 1);
        end
        repeat (20) step(1'b1);

        // Randomised hold lengths checked cycle by cycle by the scoreboard.
        for (int seg = 0; seg < 60; seg++) begin
            logic v;
            int   len;
            v   = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 45);
            repeat (len) step(v);
        end
        repeat (80) step(1'b0);

        @(posedge clk);
        #2;
        check("scoreboard_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/debouncing.md
Name: debouncing

Overview:
- Push-button debouncer.
- Synchronises an asynchronous mechanical button input to clk.
- Samples the button at a slow periodic tick through two sample flip-flops and produces a clean debounced level (dbsig) that also drives an LED.
- Both sample stages are exported for logic-analyser observation; sits between board button pins and user logic.

Parameters:
- SAMPLE_PERIOD, 16, clk cycles between sample ticks; legal range 2..2^24.
- SYNC_STAGES, 2, metastability synchroniser depth on btn; legal range 2..4.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- btn  input  1  raw button, asynchronous, active-high, may bounce.
- LED  output  1  drives board LED; lit while button is debounced-pressed.
- dbsig  output  1  debounced button level.
- button_out1  output  1  first sample stage, for logic analyser.
- button_out2  output  1  second sample stage, for logic analyser.

Behaviour:
- Reset:
  - Asserting rst_n low immediately clears the synchroniser, tick counter, button_out1, button_out2, dbsig and LED to 0.
  - Release is a plain deassert; the counter restarts from 0.
  - Reset mid-bounce discards all history.
- Synchroniser: btn passes through a SYNC_STAGES-deep flop chain; btn_s is the last stage.
- Tick generator:
  - Counter width is ceil(log2(SAMPLE_PERIOD)); counts 0..SAMPLE_PERIOD-1 and wraps to 0.
  - tick is high for exactly one clk when count == SAMPLE_PERIOD-1, i.e. the first tick is at cycle SAMPLE_PERIOD-1 after reset release.
- Sample stages: on each tick, button_out1 <= btn_s and button_out2 <= button_out1. Between ticks they hold.
- dbsig register, updated every clk:
  - button_out1 & button_out2 -> 1.
  - both 0 -> 0.
  - they differ -> hold (hysteresis).
- LED = dbsig (combinational copy).
- Latency:
  - A clean btn edge appears on dbsig after at most SYNC_STAGES + 2*SAMPLE_PERIOD + 1 clk.
  - It appears after at least SYNC_STAGES + SAMPLE_PERIOD + 1 clk.
- Glitch rejection: a btn pulse shorter than SAMPLE_PERIOD-SYNC_STAGES clk can reach at most one sample stage and never changes dbsig.
- Bounce slower than the tick can toggle dbsig; SAMPLE_PERIOD must exceed the bounce interval. Board builds override it to about 10 ms worth of cycles.
- btn changing on the tick cycle: the synchronised value at that edge is used. No special case.

Optional Feature:
- Macro DEBOUNCE_LED_TOGGLE_EN.
- When defined:
  - LED becomes a register, reset 0.
  - LED inverts for one clk after each dbsig 0->1 transition (press-to-toggle).
  - dbsig 1->0 leaves LED unchanged.
- When undefined: LED = dbsig exactly as above.
- dbsig, button_out1 and button_out2 are identical in both builds.

Decomposition:
- Package debouncing_pkg holds:
  - default constants DEF_SAMPLE_PERIOD = 16 and DEF_SYNC_STAGES = 2;
  - the counter-width function (ceil log2);
  - no typedefs required.
- One sub-module is natural: debounce_tick_gen.
  - Parameter SAMPLE_PERIOD; ports clk, rst_n, tick.
  - Implements the wrap counter.
- Synchroniser, sample stages and dbsig hysteresis stay in the top module.

Test Plan:
- Clock 20 ns, SAMPLE_PERIOD=16, SYNC_STAGES=2 for all cases.
- Reset: hold rst_n=0 with btn=1 for 10 cycles -> button_out1, button_out2, dbsig, LED all 0. They stay 0 until at least cycle 15 after release.
- Clean press: btn 0->1 at 10 ns and held for 4000 ns -> button_out1 rises on the first tick after sync and button_out2 one tick (16 cycles) later. dbsig and LED rise 1 cycle after button_out2, within 35 cycles of the btn edge, then stay 1.
- Glitch: 5-cycle btn pulses repeated every 40 cycles -> dbsig and LED remain 0 throughout.
- Release: after a stable dbsig=1, drop btn to 0 -> button_out1 then button_out2 fall on consecutive ticks. dbsig falls 1 cycle after button_out2, within 35 cycles.
- Bounce: btn toggles every 3 cycles for 30 cycles and then settles at 1 -> dbsig makes a single 0->1 transition and never returns to 0.
- Async reset mid-operation: with dbsig=1, pulse rst_n low for 3 ns between clock edges -> all outputs go to 0 without waiting for a clk edge. dbsig re-asserts within 35 cycles if btn is still 1.
- Toggle build, DEBOUNCE_LED_TOGGLE_EN defined: three clean press/release cycles -> LED sequence 1, 0, 1. dbsig identical to the default build.
